// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared types and elaboration helpers for the nibble-serial add/sub sequencer.
package serial_addsub_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_BITS  = 4;
  localparam int MIN_WIDTH = 8;

  function automatic int nib_count(input int width);
    return width / NIB_BITS;
  endfunction

  function automatic bit width_ok(input int width);
    return ((width % NIB_BITS) == 0) && (width >= MIN_WIDTH);
  endfunction

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// Operand request and result handshake bundle for serial_addsub_ctrl.
interface serial_addsub_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, result, carry_out, overflow
  );
endinterface

// File: rtl/serial_addsub_ctrl_slice.sv
// Purely combinational 4-bit ripple adder; B inversion for subtract is done by the caller.
module nibble_addsub_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
  end

  assign cout = w_c[4];
endmodule

// File: rtl/serial_addsub_ctrl.sv
// WIDTH-bit add/subtract sequenced through one 4-bit slice, LSB nibble first,
// with a registered carry between nibbles and valid/ready on both sides.
module serial_addsub_ctrl
  import serial_addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  serial_addsub_ctrl_if.slave bus
);
  localparam int NIB   = nib_count(WIDTH);
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

  if (!width_ok(WIDTH)) begin : g_width_chk
    $fatal(1, "serial_addsub_ctrl: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_sub;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic [3:0]       w_b_eff;
  logic [3:0]       w_s;
  logic             w_cout;

  // Operands shift right each step so the slice always sees bits [3:0].
  assign w_b_eff = r_b[3:0] ^ {4{r_sub}};

  nibble_addsub_slice u_slice (
    .a    (r_a[3:0]),
    .b    (w_b_eff),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_step        = 1'b0;
    w_last        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_cnt == LAST) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.op_a;
      r_b     <= bus.op_b;
      r_sub   <= bus.sub;
      r_carry <= bus.sub;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a      <= r_a >> 4;
      r_b      <= r_b >> 4;
      r_result <= {w_s, r_result[WIDTH-1:4]};
      r_carry  <= w_cout;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        r_cout <= w_cout;
        r_ovf  <= (r_a[3] == w_b_eff[3]) && (w_s[3] != r_a[3]);
      end
    end
  end

  assign bus.result    = r_result;
  assign bus.carry_out = r_cout;
  assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench: directed vector table, handshake corner sequences and
// randomized operations against an arithmetic reference model.
module tb_serial_addsub_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  serial_addsub_ctrl_if #(.WIDTH(16)) bus ();

  serial_addsub_ctrl #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] r;
    logic        c;
    logic        o;
  } vec_t;

  vec_t vecs [5];

  // Reference: whole-word arithmetic, returns {overflow, carry_out, result}.
  function automatic logic [17:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic s);
    logic [16:0] t;
    logic [15:0] r;
    logic        c;
    logic        o;
    if (!s) begin
      t = {1'b0, a} + {1'b0, b};
      r = t[15:0];
      c = t[16];
      o = (a[15] == b[15]) && (r[15] != a[15]);
    end else begin
      r = a - b;
      c = (a >= b);
      o = (a[15] != b[15]) && (r[15] != a[15]);
    end
    return {o, c, r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [15:0] er, input logic ec, input logic eo,
                       input int hold, input bit scramble);
    int w;
    int lat;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.sub       = s;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (!bus.in_ready) begin
      check({name, " accept timeout"}, 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      if (scramble) begin
        bus.op_a     = 16'($urandom);
        bus.op_b     = 16'($urandom);
        bus.sub      = 1'($urandom);
        bus.in_valid = 1'b1;
      end
      @(posedge clk); #1; lat++;
    end
    bus.in_valid = 1'b0;
    check({name, " latency"}, 32'(lat), 32'd4);
    check({name, " done"}, {bus.out_valid, bus.in_ready, bus.carry_out, bus.overflow, bus.result},
          {1'b1, 1'b0, ec, eo, er});
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.op_a     = 16'($urandom);
      @(posedge clk); #1;
      check({name, " backpressure"},
            {bus.out_valid, bus.in_ready, bus.carry_out, bus.overflow, bus.result},
            {1'b1, 1'b0, ec, eo, er});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check({name, " return idle"}, {bus.out_valid, bus.in_ready}, 2'b01);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          w;
    int          t_ov;
    int          t_acc;
    bit          saw;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;
    logic [17:0] m;

    vecs[0] = '{a: 16'h1234, b: 16'h0FFF, s: 1'b0, r: 16'h2233, c: 1'b0, o: 1'b0};
    vecs[1] = '{a: 16'hFFFF, b: 16'h0001, s: 1'b0, r: 16'h0000, c: 1'b1, o: 1'b0};
    vecs[2] = '{a: 16'h7FFF, b: 16'h0001, s: 1'b0, r: 16'h8000, c: 1'b0, o: 1'b1};
    vecs[3] = '{a: 16'h0005, b: 16'h0007, s: 1'b1, r: 16'hFFFE, c: 1'b0, o: 1'b0};
    vecs[4] = '{a: 16'h8000, b: 16'h0001, s: 1'b1, r: 16'h7FFF, c: 1'b1, o: 1'b1};

    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset state", {bus.out_valid, bus.in_ready, bus.carry_out, bus.overflow, bus.result},
          {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
            vecs[i].r, vecs[i].c, vecs[i].o, 0, 1'b0);
    end

    // Backpressure plus operand changes while running.
    do_op("bp_scramble", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 5, 1'b1);

    // Reset in the second RUN cycle.
    bus.op_a      = 16'h1234;
    bus.op_b      = 16'h0FFF;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid-run reset", {bus.out_valid, bus.in_ready, bus.carry_out, bus.overflow, bus.result},
          {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
    @(posedge clk); #1;
    rst = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) saw = 1'b1;
    end
    check("no out_valid after reset", 32'(saw), 32'd0);
    do_op("after reset", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 0, 1'b0);

    // Back-to-back with out_ready tied high; second request held during the first.
    bus.out_ready = 1'b1;
    bus.op_a      = 16'h1234;
    bus.op_b      = 16'h0FFF;
    bus.sub       = 1'b0;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.op_a = 16'hFFFF;
    bus.op_b = 16'h0001;
    w = 0;
    while (!bus.out_valid && w < 20) begin
      @(posedge clk); #1; w++;
    end
    t_ov = cyc;
    check("b2b first", {bus.out_valid, bus.carry_out, bus.overflow, bus.result},
          {1'b1, 1'b0, 1'b0, 16'h2233});
    w = 0;
    while (!bus.in_ready && w < 10) begin
      @(posedge clk); #1; w++;
    end
    t_acc = cyc + 1;
    check("b2b accept spacing", 32'(t_acc - t_ov), 32'd2);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    w = 0;
    while (!bus.out_valid && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check("b2b second", {bus.out_valid, bus.carry_out, bus.overflow, bus.result},
          {1'b1, 1'b1, 1'b0, 16'h0000});
    @(posedge clk); #1;

    for (int n = 0; n < 40; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      if (n % 8 == 0) rb = ra;
      m = ref_model(ra, rb, rs);
      do_op($sformatf("rand%0d", n), ra, rb, rs, m[15:0], m[16], m[17],
            int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
